// File: rtl/axilite_rr_arbiter.sv
// Round-robin arbiter that funnels N AXI4-lite requesters onto one downstream
// AXI4-lite port. Read and write paths are independent engines, each with its
// own FSM, round-robin pointer and a single outstanding transaction.
//
// Read FSM   state   | meaning
//            R_IDLE  | waiting for any arvalid, grants on the next edge
//            R_ADDR  | m_axi_arvalid held until m_axi_arready
//            R_DATA  | m_axi_rready held until m_axi_rvalid
//            R_RESP  | s_axi_rvalid[g] held until s_axi_rready[g]
// Write FSM  state   | meaning
//            W_IDLE  | waiting for awvalid&wvalid on one requester
//            W_ADDR  | awvalid/wvalid each held until their own ready
//            W_BWAIT | m_axi_bready held until m_axi_bvalid
//            W_RESP  | s_axi_bvalid[g] held until s_axi_bready[g]
module axilite_rr_arbiter #(
  parameter int numOfRequesters = 4
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_areset,
  input  logic [32*numOfRequesters-1:0]   s_axi_araddr,
  input  logic [3*numOfRequesters-1:0]    s_axi_arprot,
  input  logic [numOfRequesters-1:0]      s_axi_arvalid,
  output logic [numOfRequesters-1:0]      s_axi_arready,
  output logic [numOfRequesters-1:0]      s_axi_rvalid,
  input  logic [numOfRequesters-1:0]      s_axi_rready,
  output logic [31:0]                     s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  input  logic [32*numOfRequesters-1:0]   s_axi_awaddr,
  input  logic [3*numOfRequesters-1:0]    s_axi_awprot,
  input  logic [32*numOfRequesters-1:0]   s_axi_wdata,
  input  logic [4*numOfRequesters-1:0]    s_axi_wstrb,
  input  logic [numOfRequesters-1:0]      s_axi_awvalid,
  input  logic [numOfRequesters-1:0]      s_axi_wvalid,
  input  logic [numOfRequesters-1:0]      s_axi_bready,
  output logic [numOfRequesters-1:0]      s_axi_awready,
  output logic [numOfRequesters-1:0]      s_axi_wready,
  output logic [numOfRequesters-1:0]      s_axi_bvalid,
  output logic [1:0]                      s_axi_bresp,
  output logic [31:0]                     m_axi_araddr,
  output logic [2:0]                      m_axi_arprot,
  output logic                            m_axi_arvalid,
  output logic                            m_axi_rready,
  input  logic                            m_axi_arready,
  input  logic [31:0]                     m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic [31:0]                     m_axi_awaddr,
  output logic [2:0]                      m_axi_awprot,
  output logic [31:0]                     m_axi_wdata,
  output logic [3:0]                      m_axi_wstrb,
  output logic                            m_axi_awvalid,
  output logic                            m_axi_wvalid,
  output logic                            m_axi_bready,
  input  logic                            m_axi_awready,
  input  logic                            m_axi_wready,
  input  logic                            m_axi_bvalid,
  input  logic [1:0]                      m_axi_bresp
);

  localparam int N = numOfRequesters;
  // Pointer starts at the last index so that requester 0 is searched first.
  localparam logic [3:0] PTR_INIT = 4'(N - 1);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_BWAIT, W_RESP} w_state_t;

  // First requester above ptr (wrapping) with a request; ptr if none.
  function automatic logic [3:0] rr_pick(input logic [N-1:0] req, input logic [3:0] ptr);
    logic [15:0] req_w;
    logic [3:0]  pick;
    logic [3:0]  cand;
    logic        found;
    req_w = '0;
    req_w[N-1:0] = req;
    pick = ptr;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = 4'((int'(ptr) + k) % N);
      if (!found && req_w[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  r_state_t    r_state, r_next;
  logic [3:0]  r_ptr, r_idx, r_gnt;
  logic        ar_pulse;
  logic [31:0] r_sel_addr;
  logic [2:0]  r_sel_prot;
  logic        r_rready_g;

  w_state_t    w_state, w_next;
  logic [3:0]  w_ptr, w_idx, w_gnt;
  logic        aw_pulse, aw_done, w_done, aw_fire, w_fire;
  logic [N-1:0] w_req;
  logic [31:0] w_sel_addr, w_sel_data;
  logic [2:0]  w_sel_prot;
  logic [3:0]  w_sel_strb;
  logic        w_bready_g;

  assign w_req   = s_axi_awvalid & s_axi_wvalid;
  assign r_gnt   = rr_pick(s_axi_arvalid, r_ptr);
  assign w_gnt   = rr_pick(w_req, w_ptr);
  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign w_fire  = m_axi_wvalid && m_axi_wready;

  // Select the candidate requester's request fields and the granted one's ready.
  always_comb begin
    r_sel_addr = '0;
    r_sel_prot = '0;
    r_rready_g = 1'b0;
    w_sel_addr = '0;
    w_sel_prot = '0;
    w_sel_data = '0;
    w_sel_strb = '0;
    w_bready_g = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_gnt == 4'(i)) begin
        r_sel_addr = s_axi_araddr[i*32 +: 32];
        r_sel_prot = s_axi_arprot[i*3 +: 3];
      end
      if (r_idx == 4'(i)) r_rready_g = s_axi_rready[i];
      if (w_gnt == 4'(i)) begin
        w_sel_addr = s_axi_awaddr[i*32 +: 32];
        w_sel_prot = s_axi_awprot[i*3 +: 3];
        w_sel_data = s_axi_wdata[i*32 +: 32];
        w_sel_strb = s_axi_wstrb[i*4 +: 4];
      end
      if (w_idx == 4'(i)) w_bready_g = s_axi_bready[i];
    end
  end

  // Read FSM state register.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_state <= R_IDLE;
    else              r_state <= r_next;
  end

  // Read FSM next-state logic.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (|s_axi_arvalid) r_next = R_ADDR;
      R_ADDR:  if (m_axi_arready)  r_next = R_DATA;
      R_DATA:  if (m_axi_rvalid)   r_next = R_RESP;
      R_RESP:  if (r_rready_g)     r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read datapath: grant latch, pointer update and response capture.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_ptr        <= PTR_INIT;
      r_idx        <= '0;
      ar_pulse     <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arprot <= '0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= '0;
    end else begin
      ar_pulse <= 1'b0;
      case (r_state)
        R_IDLE: if (|s_axi_arvalid) begin
          m_axi_araddr <= r_sel_addr;
          m_axi_arprot <= r_sel_prot;
          r_idx        <= r_gnt;
          r_ptr        <= r_gnt;
          ar_pulse     <= 1'b1;
        end
        R_DATA: if (m_axi_rvalid) begin
          s_axi_rdata <= m_axi_rdata;
          s_axi_rresp <= m_axi_rresp;
        end
        R_RESP: if (r_rready_g) begin
          s_axi_rdata <= '0;
          s_axi_rresp <= '0;
        end
        default: ;
      endcase
    end
  end

  // Read handshake outputs, routed only to the granted index.
  always_comb begin
    m_axi_arvalid = (r_state == R_ADDR);
    m_axi_rready  = (r_state == R_DATA);
    s_axi_arready = '0;
    s_axi_rvalid  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == 4'(i)) begin
        s_axi_arready[i] = ar_pulse;
        s_axi_rvalid[i]  = (r_state == R_RESP);
      end
    end
  end

  // Write FSM state register.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) w_state <= W_IDLE;
    else              w_state <= w_next;
  end

  // Write FSM next-state logic; address and data may complete in either order.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (|w_req) w_next = W_ADDR;
      W_ADDR:  if ((aw_done || aw_fire) && (w_done || w_fire)) w_next = W_BWAIT;
      W_BWAIT: if (m_axi_bvalid) w_next = W_RESP;
      W_RESP:  if (w_bready_g)   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write datapath: grant latch, per-channel completion flags, bresp capture.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      w_ptr        <= PTR_INIT;
      w_idx        <= '0;
      aw_pulse     <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      m_axi_awaddr <= '0;
      m_axi_awprot <= '0;
      m_axi_wdata  <= '0;
      m_axi_wstrb  <= '0;
      s_axi_bresp  <= '0;
    end else begin
      aw_pulse <= 1'b0;
      case (w_state)
        W_IDLE: if (|w_req) begin
          m_axi_awaddr <= w_sel_addr;
          m_axi_awprot <= w_sel_prot;
          m_axi_wdata  <= w_sel_data;
          m_axi_wstrb  <= w_sel_strb;
          w_idx        <= w_gnt;
          w_ptr        <= w_gnt;
          aw_pulse     <= 1'b1;
          aw_done      <= 1'b0;
          w_done       <= 1'b0;
        end
        W_ADDR: begin
          if (aw_fire) aw_done <= 1'b1;
          if (w_fire)  w_done  <= 1'b1;
        end
        W_BWAIT: if (m_axi_bvalid) s_axi_bresp <= m_axi_bresp;
        W_RESP:  if (w_bready_g)   s_axi_bresp <= '0;
        default: ;
      endcase
    end
  end

  // Write handshake outputs, routed only to the granted index.
  always_comb begin
    m_axi_awvalid = (w_state == W_ADDR) && !aw_done;
    m_axi_wvalid  = (w_state == W_ADDR) && !w_done;
    m_axi_bready  = (w_state == W_BWAIT);
    s_axi_awready = '0;
    s_axi_wready  = '0;
    s_axi_bvalid  = '0;
    for (int i = 0; i < N; i++) begin
      if (w_idx == 4'(i)) begin
        s_axi_awready[i] = aw_pulse;
        s_axi_wready[i]  = aw_pulse;
        s_axi_bvalid[i]  = (w_state == W_RESP);
      end
    end
  end

endmodule

// File: tb/tb_axilite_rr_arbiter.sv
// Directed bench for axilite_rr_arbiter with N=4: a table of read vectors
// plus hand-written multi-cycle sequences for writes, concurrency and reset.
module tb_axilite_rr_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [32*N-1:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata;
  logic [3*N-1:0]  s_axi_arprot, s_axi_awprot;
  logic [4*N-1:0]  s_axi_wstrb;
  logic [N-1:0]    s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [N-1:0]    s_axi_awvalid, s_axi_wvalid, s_axi_bready;
  logic [N-1:0]    s_axi_awready, s_axi_wready, s_axi_bvalid;
  logic [31:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp, s_axi_bresp;
  logic [31:0]     m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic [2:0]      m_axi_arprot, m_axi_awprot;
  logic [3:0]      m_axi_wstrb;
  logic [1:0]      m_axi_rresp, m_axi_bresp;
  logic m_axi_arvalid, m_axi_rready, m_axi_arready, m_axi_rvalid;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic m_axi_awready, m_axi_wready, m_axi_bvalid;

  axilite_rr_arbiter #(.numOfRequesters(N)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_bready(s_axi_bready), .s_axi_awready(s_axi_awready),
    .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bresp(s_axi_bresp),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_rready(m_axi_rready),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_bready(m_axi_bready), .m_axi_awready(m_axi_awready),
    .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          exp_g;
  } rd_vec_t;

  rd_vec_t     vecs [7];
  logic [31:0] ar_addr [N];
  logic [2:0]  ar_prot [N];
  logic [31:0] aw_addr [N];
  logic [2:0]  aw_prot [N];
  logic [31:0] w_data  [N];
  logic [3:0]  w_strb  [N];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = 15;
    for (int i = 0; i < N; i++) if (v == (N'(1) << i)) r = i;
    return r;
  endfunction

  task automatic wait_ar_grant();
    int n;
    n = 0;
    while (s_axi_arready == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_aw_grant();
    int n;
    n = 0;
    while (s_axi_awready == '0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input rd_vec_t v, input string tag);
    logic [N-1:0] oh;
    oh = N'(1) << v.exp_g;
    s_axi_arvalid = v.mask;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    wait_ar_grant();
    check({tag, "_arready"}, s_axi_arready, oh);
    s_axi_arvalid = '0;
    check({tag, "_araddr"}, m_axi_araddr, ar_addr[v.exp_g]);
    check({tag, "_arprot"}, m_axi_arprot, ar_prot[v.exp_g]);
    check({tag, "_arvalid"}, m_axi_arvalid, 1);
    tick();
    check({tag, "_rready"}, {m_axi_arvalid, m_axi_rready}, 2'b01);
    m_axi_rvalid = 1'b1;
    m_axi_rdata  = v.rdata;
    m_axi_rresp  = v.rresp;
    tick();
    m_axi_rvalid = 1'b0;
    check({tag, "_rvalid"}, s_axi_rvalid, oh);
    check({tag, "_rdata"}, s_axi_rdata, v.rdata);
    check({tag, "_rresp"}, s_axi_rresp, v.rresp);
    s_axi_rready = oh;
    tick();
    s_axi_rready = '0;
    check({tag, "_rvalid_clr"}, s_axi_rvalid, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int got [6];
    int exp_order [6];
    int k, cyc;

    ar_addr = '{32'h0000_0100, 32'h0000_0204, 32'h0000_0010, 32'h0000_030C};
    ar_prot = '{3'd2, 3'd3, 3'd4, 3'd5};
    aw_addr = '{32'h2000_0000, 32'h2000_0040, 32'h2000_0080, 32'h2000_00C0};
    aw_prot = '{3'd7, 3'd6, 3'd5, 3'd4};
    w_data  = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003};
    w_strb  = '{4'hF, 4'h3, 4'hC, 4'h5};
    for (int i = 0; i < N; i++) begin
      s_axi_araddr[i*32 +: 32] = ar_addr[i];
      s_axi_arprot[i*3 +: 3]   = ar_prot[i];
      s_axi_awaddr[i*32 +: 32] = aw_addr[i];
      s_axi_awprot[i*3 +: 3]   = aw_prot[i];
      s_axi_wdata[i*32 +: 32]  = w_data[i];
      s_axi_wstrb[i*4 +: 4]    = w_strb[i];
    end

    // mask, rdata, rresp, expected grant (pointer 3 after reset)
    vecs[0] = '{4'b0100, 32'hDEAD_BEEF, 2'b00, 2};
    vecs[1] = '{4'b1111, 32'h1111_2222, 2'b00, 3};
    vecs[2] = '{4'b1111, 32'h3333_4444, 2'b01, 0};
    vecs[3] = '{4'b0110, 32'h5555_6666, 2'b10, 1};
    vecs[4] = '{4'b0011, 32'h7777_8888, 2'b11, 0};
    vecs[5] = '{4'b1010, 32'h9999_AAAA, 2'b01, 1};
    vecs[6] = '{4'b1000, 32'hBBBB_CCCC, 2'b10, 3};
    exp_order = '{0, 1, 2, 3, 0, 1};

    rst = 1'b1;
    s_axi_arvalid = '0; s_axi_rready = '0;
    s_axi_awvalid = '0; s_axi_wvalid = '0; s_axi_bready = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = '0;
    repeat (3) tick();
    check("rst_s_hs", {s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_bvalid}, 0);
    check("rst_m_hs", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("rst_data", {m_axi_araddr, m_axi_awaddr, s_axi_rdata}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) do_read(vecs[i], $sformatf("vec%0d", i));

    // Fairness: everyone requesting continuously, slave always ready.
    for (int i = 0; i < 6; i++) got[i] = -1;
    s_axi_arvalid = '1; s_axi_rready = '1;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0F0F_0F0F; m_axi_rresp = 2'b00;
    k = 0; cyc = 0;
    while (k < 6 && cyc < 100) begin
      tick();
      cyc++;
      if (s_axi_arready != '0) begin
        got[k] = onehot_idx(s_axi_arready);
        k++;
      end
    end
    s_axi_arvalid = '0;
    for (int i = 0; i < 6; i++) check($sformatf("fair_grant%0d", i), 64'(got[i]), 64'(exp_order[i]));
    repeat (6) tick();
    s_axi_rready = '0; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;

    // Split write acceptance on requester 1.
    s_axi_awvalid = 4'b0010; s_axi_wvalid = 4'b0010;
    wait_aw_grant();
    check("sw_awready", s_axi_awready, 4'b0010);
    check("sw_wready", s_axi_wready, 4'b0010);
    s_axi_awvalid = '0; s_axi_wvalid = '0;
    check("sw_awaddr", m_axi_awaddr, aw_addr[1]);
    check("sw_wdata", {m_axi_wstrb, m_axi_awprot, m_axi_wdata}, {w_strb[1], aw_prot[1], w_data[1]});
    check("sw_c0_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b110);
    m_axi_awready = 1'b1;
    tick();
    m_axi_awready = 1'b0;
    check("sw_c1_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    tick();
    check("sw_c2_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    tick();
    check("sw_c3_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b010);
    m_axi_wready = 1'b1;
    tick();
    m_axi_wready = 1'b0;
    check("sw_c4_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 3'b001);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    tick();
    m_axi_bvalid = 1'b0;
    check("sw_bvalid", s_axi_bvalid, 4'b0010);
    check("sw_bresp", s_axi_bresp, 2'b10);
    check("sw_bready_clr", m_axi_bready, 0);
    s_axi_bready = 4'b0010;
    tick();
    s_axi_bready = '0;
    check("sw_bvalid_clr", s_axi_bvalid, 0);

    // Concurrent read by requester 1 and write by requester 3.
    s_axi_arvalid = 4'b0010; s_axi_awvalid = 4'b1000; s_axi_wvalid = 4'b1000;
    wait_ar_grant();
    check("cc_arready", s_axi_arready, 4'b0010);
    check("cc_awready", {s_axi_awready, s_axi_wready}, 8'b1000_1000);
    s_axi_arvalid = '0; s_axi_awvalid = '0; s_axi_wvalid = '0;
    check("cc_both_active", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 3'b111);
    tick();
    check("cc_hold", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid}, 3'b111);
    check("cc_araddr_stable", m_axi_araddr, ar_addr[1]);
    m_axi_arready = 1'b1; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    tick();
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    check("cc_readies", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b00011);
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678; m_axi_rresp = 2'b00;
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b11;
    tick();
    m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
    check("cc_rvalid", s_axi_rvalid, 4'b0010);
    check("cc_rdata", s_axi_rdata, 32'h1234_5678);
    check("cc_bvalid", s_axi_bvalid, 4'b1000);
    check("cc_bresp", s_axi_bresp, 2'b11);
    s_axi_rready = 4'b0010; s_axi_bready = 4'b1000;
    tick();
    s_axi_rready = '0; s_axi_bready = '0;
    check("cc_clr", {s_axi_rvalid, s_axi_bvalid}, 0);

    // Back-pressure on requester 0 for ten cycles.
    s_axi_arvalid = 4'b0001;
    wait_ar_grant();
    check("bp_arready", s_axi_arready, 4'b0001);
    s_axi_arvalid = '0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rdata = 32'hCAFE_F00D; m_axi_rresp = 2'b01;
    tick();
    m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    for (int c = 0; c < 10; c++) begin
      check("bp_rvalid", s_axi_rvalid, 4'b0001);
      check("bp_rdata", {s_axi_rresp, s_axi_rdata}, {2'b01, 32'hCAFE_F00D});
      tick();
    end
    s_axi_rready = 4'b0001;
    tick();
    s_axi_rready = '0;
    check("bp_clr", s_axi_rvalid, 0);

    // Reset while requester 2's read sits in R_DATA.
    s_axi_arvalid = 4'b0100;
    wait_ar_grant();
    check("rr_arready", s_axi_arready, 4'b0100);
    s_axi_arvalid = '0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    check("rr_in_rdata", {m_axi_rready, m_axi_araddr}, {1'b1, ar_addr[2]});
    #2;
    rst = 1'b1;
    #1;
    check("rr_m_hs", {m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}, 0);
    check("rr_s_hs", {s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_wready, s_axi_bvalid}, 0);
    check("rr_addr", {m_axi_araddr, m_axi_arprot, m_axi_awaddr}, 0);
    check("rr_wdata", {m_axi_wdata, m_axi_wstrb, s_axi_rdata, s_axi_bresp}, 0);
    s_axi_arvalid = '1;
    tick();
    rst = 1'b0;
    tick();
    check("rr_first_grant", s_axi_arready, 4'b0001);
    check("rr_no_resp", s_axi_rvalid, 0);
    s_axi_arvalid = '0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axilite_rr_arbiter.md
AXILITE_RR_ARBITER -- requirements
Module: axilite_rr_arbiter

Interface
REQ-001 Parameter numOfRequesters, default 4, gives the number of upstream AXI4-lite requesters; the legal range is 2..16 and the grant index is 4 bits.
REQ-002 Port s_axi_aclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port s_axi_areset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Ports s_axi_araddr and s_axi_arprot, inputs, 32*N and 3*N bits: requester read address and protection; slot i is at [i*W+:W].
REQ-005 Ports s_axi_arvalid and s_axi_rready, inputs, N bits each; ports s_axi_arready and s_axi_rvalid, outputs, N bits each: per-requester read handshakes.
REQ-006 Ports s_axi_rdata and s_axi_rresp, outputs, 32 and 2 bits: shared read return buses, qualified by s_axi_rvalid[i].
REQ-007 Ports s_axi_awaddr, s_axi_awprot, s_axi_wdata and s_axi_wstrb, inputs, 32*N, 3*N, 32*N and 4*N bits: requester write address, protection, data and strobe.
REQ-008 Ports s_axi_awvalid, s_axi_wvalid and s_axi_bready, inputs, N bits each; ports s_axi_awready, s_axi_wready and s_axi_bvalid, outputs, N bits each: per-requester write handshakes.
REQ-009 Port s_axi_bresp, output, 2 bits: shared write response bus, qualified by s_axi_bvalid[i].
REQ-010 Ports m_axi_araddr, m_axi_arprot, m_axi_arvalid and m_axi_rready, outputs, 32, 3, 1 and 1 bits; ports m_axi_arready, m_axi_rdata, m_axi_rresp and m_axi_rvalid, inputs, 1, 32, 2 and 1 bits: downstream read channel toward the interconnect slave port.
REQ-011 Ports m_axi_awaddr, m_axi_awprot, m_axi_wdata, m_axi_wstrb, m_axi_awvalid, m_axi_wvalid and m_axi_bready, outputs, 32, 3, 32, 4, 1, 1 and 1 bits: downstream write request channel.
REQ-012 Ports m_axi_awready, m_axi_wready, m_axi_bvalid and m_axi_bresp, inputs, 1, 1, 1 and 2 bits: downstream write acceptance and response.

Function
REQ-013 The read and write paths SHALL be independent engines, each with its own FSM and round-robin pointer, and each with at most one outstanding transaction.
REQ-014 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA and R_RESP; write FSM states SHALL be W_IDLE, W_ADDR, W_BWAIT and W_RESP.
REQ-015 Round-robin selection SHALL search from pointer+1 upward with wrap at N-1->0; on each grant the pointer SHALL be set to the granted index.
REQ-016 A read request is s_axi_arvalid[i]; a write request is s_axi_awvalid[i] AND s_axi_wvalid[i], so a requester with only one of the two is never granted.
REQ-017 In R_IDLE, when any request is present at edge k: latch the granted requester's address, prot and index; assert s_axi_arready[g] for exactly the one cycle after edge k; drive m_axi_arvalid=1; move to R_ADDR.
REQ-018 In R_ADDR, when m_axi_arready=1: clear m_axi_arvalid, set m_axi_rready=1, move to R_DATA; m_axi_araddr and m_axi_arprot SHALL stay stable while m_axi_arvalid=1.
REQ-019 In R_DATA, when m_axi_rvalid=1: register m_axi_rdata and m_axi_rresp onto s_axi_rdata and s_axi_rresp, set s_axi_rvalid[g]=1, clear m_axi_rready, move to R_RESP.
REQ-020 In R_RESP, s_axi_rvalid[g] and the data SHALL hold until s_axi_rready[g]=1, then clear, and the FSM returns to R_IDLE; it SHALL NOT grant again in the same cycle.
REQ-021 In W_IDLE, write grant mirrors REQ-017: latch awaddr, awprot, wdata, wstrb and index; pulse s_axi_awready[g] and s_axi_wready[g] together for one cycle; drive m_axi_awvalid=1 and m_axi_wvalid=1; move to W_ADDR.
REQ-022 In W_ADDR, m_axi_awvalid and m_axi_wvalid SHALL each deassert independently on their own ready; when both are done (same-cycle completion included), set m_axi_bready=1 and move to W_BWAIT.
REQ-023 In W_BWAIT, when m_axi_bvalid=1: register bresp, set s_axi_bvalid[g]=1, clear m_axi_bready, move to W_RESP; leave W_RESP on s_axi_bready[g]=1.
REQ-024 s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid and s_axi_bvalid SHALL each be zero for every non-granted index at all times.
REQ-025 Downstream RESP/BRESP values SHALL pass through unmodified, including SLVERR and DECERR.

Reset
REQ-026 While s_axi_areset=1, the block SHALL immediately clear every valid and ready output, clear all data, address, prot, strobe and resp outputs to 0, set both FSMs to IDLE and set both pointers to N-1 so that requester 0 wins first.
REQ-027 Reset during an in-flight transaction SHALL abandon it with no upstream response, and a new grant may occur on the first edge after release.

Verification
REQ-028 Single read: N=4, requester 2 reads 0x0000_0010 with the downstream slave ready and returning 0xDEAD_BEEF/OKAY -> m_axi_araddr=0x10 is seen, s_axi_rvalid[2]=1 with rdata=0xDEAD_BEEF, and no other index toggles.
REQ-029 Fairness: all 4 requesters hold arvalid continuously -> the grant order is 0,1,2,3,0,1, and no requester is granted twice before all others are granted once.
REQ-030 Split write acceptance: m_axi_awready is high at cycle 0 and m_axi_wready high at cycle 3 -> awvalid drops after cycle 0, wvalid drops after cycle 3, and m_axi_bready rises the cycle after.
REQ-031 Concurrency: requester 1 reads while requester 3 writes in the same cycle -> both downstream channels are active at the same time, and both responses are routed to the correct index.
REQ-032 Back-pressure and reset: hold s_axi_rready[0]=0 for 10 cycles -> rvalid and rdata are held stable; asserting reset in R_DATA clears all outputs at once, and the next grant goes to requester 0.
